rename_map: RTL and testbench

Parametrised register-rename unit for the out-of-order core: maps architectural source/destination registers to physical tags, allocates destinations from a bitmap free list, and tracks per-tag ready bits. It sits between decode and dispatch and is fed back by complete and retire. Beyond single-table renaming, it adds a valid/ready stall handshake, a committed (retirement) map, correct freeing of the previous mapping at retire, and a one-cycle flush that restores the speculative map.

---
 rtl/rename_map.sv | 143 ++++++++++++++
 tb/tb_rename_map.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rename_map.sv
// Register-rename unit: speculative and committed maps, a bitmap free list and per-tag ready bits.
// Renames one instruction per cycle; complete, retire and flush feed back into the tables.
module rename_map #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int AW = $clog2(ARCH_REGS),
  parameter int PW = $clog2(PHYS_REGS),
  parameter int CW = $clog2(PHYS_REGS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic          rd_wen,
  output logic [PW-1:0] phys_rs1,
  output logic [PW-1:0] phys_rs2,
  output logic          rs1_ready,
  output logic          rs2_ready,
  output logic [PW-1:0] phys_rd,
  output logic [PW-1:0] old_phys_rd,
  input  logic          complete_valid,
  input  logic [PW-1:0] complete_phys,
  input  logic          retire_valid,
  input  logic [AW-1:0] retire_arch_rd,
  input  logic [PW-1:0] retire_phys_rd,
  input  logic [PW-1:0] retire_old_phys_rd,
  input  logic          flush,
  output logic [CW-1:0] free_count,
  output logic          free_list_empty
);

  logic [PW-1:0]        spec_rat_q   [ARCH_REGS];
  logic [PW-1:0]        spec_rat_d   [ARCH_REGS];
  logic [PW-1:0]        commit_rat_q [ARCH_REGS];
  logic [PW-1:0]        commit_rat_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_q, free_d;
  logic [PHYS_REGS-1:0] ready_q, ready_d;
  logic [CW-1:0]        free_count_q, free_count_d;

  logic                 alloc_needed;
  logic                 fire;
  logic                 do_alloc;
  logic [PW-1:0]        alloc_tag;
  logic [PW-1:0]        src1_tag, src2_tag;
  logic                 src1_rdy, src2_rdy;
  logic [PHYS_REGS-1:0] referenced;

  assign alloc_needed = rd_wen && (rd != '0);
  // Gating with reset_n keeps a handshake from completing while reset is held.
  assign in_ready     = reset_n && !flush && (!alloc_needed || (free_count_q != '0));
  assign fire         = in_valid && in_ready;
  assign do_alloc     = fire && alloc_needed;

  // Lowest-index free tag: descending scan, so the last hit is the lowest.
  always_comb begin
    alloc_tag = '0;
    for (int t = PHYS_REGS - 1; t >= 0; t--) begin
      if (free_q[t]) alloc_tag = PW'(t);
    end
  end

  always_comb begin
    src1_tag = (rs1 == '0) ? '0 : spec_rat_q[rs1];
    src2_tag = (rs2 == '0) ? '0 : spec_rat_q[rs2];
    src1_rdy = (rs1 == '0) || ready_q[src1_tag] || (complete_valid && (complete_phys == src1_tag));
    src2_rdy = (rs2 == '0) || ready_q[src2_tag] || (complete_valid && (complete_phys == src2_tag));
  end

  assign phys_rs1        = fire ? src1_tag : '0;
  assign phys_rs2        = fire ? src2_tag : '0;
  assign rs1_ready       = fire && src1_rdy;
  assign rs2_ready       = fire && src2_rdy;
  assign phys_rd         = do_alloc ? alloc_tag : '0;
  assign old_phys_rd     = do_alloc ? spec_rat_q[rd] : '0;
  assign free_count      = free_count_q;
  assign free_list_empty = (free_count_q == '0);

  always_comb begin
    commit_rat_d = commit_rat_q;
    if (retire_valid && (retire_arch_rd != '0)) commit_rat_d[retire_arch_rd] = retire_phys_rd;
  end

  // Tags still held by the post-retire committed map; a flush frees all others.
  generate
    for (genvar gi = 0; gi < PHYS_REGS; gi++) begin : g_ref
      logic hit;
      always_comb begin
        hit = 1'b0;
        for (int a = 0; a < ARCH_REGS; a++) begin
          if (commit_rat_d[a] == PW'(gi)) hit = 1'b1;
        end
      end
      assign referenced[gi] = hit;
    end
  endgenerate

  always_comb begin
    spec_rat_d = spec_rat_q;
    free_d     = free_q;
    ready_d    = ready_q;
    if (retire_valid && (retire_old_phys_rd != '0)) free_d[retire_old_phys_rd] = 1'b1;
    if (complete_valid && (complete_phys != '0)) ready_d[complete_phys] = 1'b1;
    // Applied after complete so an allocation's ready clear wins on the same tag.
    if (do_alloc) begin
      spec_rat_d[rd]    = alloc_tag;
      free_d[alloc_tag]  = 1'b0;
      ready_d[alloc_tag] = 1'b0;
    end
    if (flush) begin
      for (int a = 0; a < ARCH_REGS; a++) spec_rat_d[a] = commit_rat_d[a];
      ready_d   = '1;
      free_d    = ~referenced;
      free_d[0] = 1'b0;
    end
  end

  always_comb begin
    free_count_d = '0;
    for (int t = 0; t < PHYS_REGS; t++) free_count_d = free_count_d + CW'(free_d[t]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < ARCH_REGS; a++) begin
        spec_rat_q[a]   <= PW'(a);
        commit_rat_q[a] <= PW'(a);
      end
      for (int t = 0; t < PHYS_REGS; t++) free_q[t] <= (t >= ARCH_REGS);
      ready_q      <= '1;
      free_count_q <= CW'(PHYS_REGS - ARCH_REGS);
    end else begin
      spec_rat_q   <= spec_rat_d;
      commit_rat_q <= commit_rat_d;
      free_q       <= free_d;
      ready_q      <= ready_d;
      free_count_q <= free_count_d;
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map: reset, chaining, exhaustion, bypass, flush, x0 and async reset.
module tb_rename_map;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int AW = 5;
  localparam int PW = 6;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid, in_ready;
  logic [AW-1:0] rs1, rs2, rd;
  logic          rd_wen;
  logic [PW-1:0] phys_rs1, phys_rs2, phys_rd, old_phys_rd;
  logic          rs1_ready, rs2_ready;
  logic          complete_valid;
  logic [PW-1:0] complete_phys;
  logic          retire_valid;
  logic [AW-1:0] retire_arch_rd;
  logic [PW-1:0] retire_phys_rd, retire_old_phys_rd;
  logic          flush;
  logic [CW-1:0] free_count;
  logic          free_list_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_map #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_wen(rd_wen),
    .phys_rs1(phys_rs1), .phys_rs2(phys_rs2),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .phys_rd(phys_rd), .old_phys_rd(old_phys_rd),
    .complete_valid(complete_valid), .complete_phys(complete_phys),
    .retire_valid(retire_valid), .retire_arch_rd(retire_arch_rd),
    .retire_phys_rd(retire_phys_rd), .retire_old_phys_rd(retire_old_phys_rd),
    .flush(flush), .free_count(free_count), .free_list_empty(free_list_empty)
  );

  task automatic idle_inputs();
    in_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rd_wen = 0;
    complete_valid = 0; complete_phys = 0;
    retire_valid = 0; retire_arch_rd = 0; retire_phys_rd = 0; retire_old_phys_rd = 0;
    flush = 0;
  endtask

  task automatic rename_in(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic [AW-1:0] d, input logic wen);
    in_valid = 1; rs1 = s1; rs2 = s2; rd = d; rd_wen = wen;
    $display("rename rs1=%0d rs2=%0d rd=%0d wen=%0d", s1, s2, d, wen);
  endtask

  task automatic step();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL reset_free_count: got %0d expected 32", free_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (free_list_empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %0b expected 0", free_list_empty); end
    step(); rs1 = 5; #1;
    checks++; if (phys_rs1 !== 6'd0 || rs1_ready !== 1'b0) begin errors++; $display("FAIL idle_outputs: got tag %0d rdy %0b expected 0 0", phys_rs1, rs1_ready); end
    step(); rename_in(5, 0, 0, 0); #1;
    checks++; if (phys_rs1 !== 6'd5 || rs1_ready !== 1'b1) begin errors++; $display("FAIL reset_rs1: got tag %0d rdy %0b expected 5 1", phys_rs1, rs1_ready); end
    checks++; if (phys_rs2 !== 6'd0 || rs2_ready !== 1'b1) begin errors++; $display("FAIL reset_rs2_x0: got tag %0d rdy %0b expected 0 1", phys_rs2, rs2_ready); end
    checks++; if (phys_rd !== 6'd0) begin errors++; $display("FAIL reset_no_alloc: got %0d expected 0", phys_rd); end
  endtask

  task automatic test_chain();
    do_reset();
    step(); rename_in(0, 0, 3, 1); #1;
    checks++; if (phys_rd !== 6'd32 || old_phys_rd !== 6'd3) begin errors++; $display("FAIL chain_first: got phys %0d old %0d expected 32 3", phys_rd, old_phys_rd); end
    step(); rename_in(3, 0, 3, 1); #1;
    checks++; if (phys_rs1 !== 6'd32 || rs1_ready !== 1'b0) begin errors++; $display("FAIL chain_src: got tag %0d rdy %0b expected 32 0", phys_rs1, rs1_ready); end
    checks++; if (phys_rd !== 6'd33 || old_phys_rd !== 6'd32) begin errors++; $display("FAIL chain_second: got phys %0d old %0d expected 33 32", phys_rd, old_phys_rd); end
    step(); #1;
    checks++; if (free_count !== 7'd30) begin errors++; $display("FAIL chain_count: got %0d expected 30", free_count); end
  endtask

  task automatic test_exhaust();
    logic [PW-1:0] exp_tag;
    logic [AW-1:0] d;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step();
      d = AW'((i % 31) + 1);
      rename_in(0, 0, d, 1);
      #1;
      exp_tag = PW'(32 + i);
      checks++; if (phys_rd !== exp_tag) begin errors++; $display("FAIL exhaust_alloc%0d: got %0d expected %0d", i, phys_rd, exp_tag); end
    end
    step(); #1;
    checks++; if (free_list_empty !== 1'b1 || free_count !== 7'd0) begin errors++; $display("FAIL exhaust_empty: got empty %0b count %0d expected 1 0", free_list_empty, free_count); end
    step(); rename_in(0, 0, 2, 1); #1;
    checks++; if (in_ready !== 1'b0 || phys_rd !== 6'd0) begin errors++; $display("FAIL exhaust_stall: got ready %0b phys %0d expected 0 0", in_ready, phys_rd); end
    step(); rename_in(1, 0, 2, 0); #1;
    checks++; if (in_ready !== 1'b1 || phys_rs1 !== 6'd63) begin errors++; $display("FAIL exhaust_nowrite: got ready %0b rs1 %0d expected 1 63", in_ready, phys_rs1); end
    step();
    retire_valid = 1; retire_arch_rd = 7; retire_phys_rd = 38; retire_old_phys_rd = 7;
    rename_in(0, 0, 2, 1); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL exhaust_retire_same_cycle: got ready %0b expected 0", in_ready); end
    step(); rename_in(0, 0, 2, 1); #1;
    checks++; if (in_ready !== 1'b1 || phys_rd !== 6'd7 || old_phys_rd !== 6'd33) begin errors++; $display("FAIL exhaust_realloc: got ready %0b phys %0d old %0d expected 1 7 33", in_ready, phys_rd, old_phys_rd); end
    step(); #1;
    checks++; if (free_count !== 7'd0) begin errors++; $display("FAIL exhaust_final_count: got %0d expected 0", free_count); end
  endtask

  task automatic test_bypass();
    do_reset();
    step(); rename_in(0, 0, 3, 1); #1;
    step(); complete_valid = 1; complete_phys = 32; rename_in(3, 3, 0, 0); #1;
    checks++; if (phys_rs1 !== 6'd32 || rs1_ready !== 1'b1 || rs2_ready !== 1'b1) begin errors++; $display("FAIL bypass_same_cycle: got tag %0d rdy %0b/%0b expected 32 1/1", phys_rs1, rs1_ready, rs2_ready); end
    step(); rename_in(3, 0, 0, 0); #1;
    checks++; if (rs1_ready !== 1'b1) begin errors++; $display("FAIL bypass_registered: got %0b expected 1", rs1_ready); end
    step(); complete_valid = 1; complete_phys = 33; rename_in(0, 0, 4, 1); #1;
    checks++; if (phys_rd !== 6'd33) begin errors++; $display("FAIL alloc_vs_complete_tag: got %0d expected 33", phys_rd); end
    step(); rename_in(4, 0, 0, 0); #1;
    checks++; if (phys_rs1 !== 6'd33 || rs1_ready !== 1'b0) begin errors++; $display("FAIL alloc_clear_wins: got tag %0d rdy %0b expected 33 0", phys_rs1, rs1_ready); end
  endtask

  task automatic test_flush();
    do_reset();
    step(); rename_in(0, 0, 4, 1); #1;
    step(); rename_in(0, 0, 5, 1); #1;
    checks++; if (phys_rd !== 6'd33) begin errors++; $display("FAIL flush_setup: got %0d expected 33", phys_rd); end
    step();
    retire_valid = 1; retire_arch_rd = 4; retire_phys_rd = 32; retire_old_phys_rd = 4;
    flush = 1; rename_in(0, 0, 6, 1); #1;
    checks++; if (in_ready !== 1'b0 || phys_rd !== 6'd0) begin errors++; $display("FAIL flush_blocks_fire: got ready %0b phys %0d expected 0 0", in_ready, phys_rd); end
    step(); #1;
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL flush_count: got %0d expected 32", free_count); end
    step(); rename_in(4, 5, 0, 0); #1;
    checks++; if (phys_rs1 !== 6'd32 || phys_rs2 !== 6'd5) begin errors++; $display("FAIL flush_map: got %0d %0d expected 32 5", phys_rs1, phys_rs2); end
    checks++; if (rs1_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b expected 1", rs1_ready); end
    step(); rename_in(0, 0, 6, 1); #1;
    checks++; if (phys_rd !== 6'd4 || old_phys_rd !== 6'd6) begin errors++; $display("FAIL flush_free4: got phys %0d old %0d expected 4 6", phys_rd, old_phys_rd); end
    step(); rename_in(0, 0, 7, 1); #1;
    checks++; if (phys_rd !== 6'd33) begin errors++; $display("FAIL flush_free33: got %0d expected 33", phys_rd); end
  endtask

  task automatic test_x0();
    do_reset();
    step(); rename_in(0, 0, 0, 1); #1;
    checks++; if (in_ready !== 1'b1 || phys_rd !== 6'd0 || old_phys_rd !== 6'd0) begin errors++; $display("FAIL x0_rename: got ready %0b phys %0d old %0d expected 1 0 0", in_ready, phys_rd, old_phys_rd); end
    step();
    complete_valid = 1; complete_phys = 0;
    retire_valid = 1; retire_arch_rd = 0; retire_phys_rd = 0; retire_old_phys_rd = 0;
    #1;
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL x0_count_after_rename: got %0d expected 32", free_count); end
    step(); #1;
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL x0_count_after_retire: got %0d expected 32", free_count); end
    step(); rename_in(0, 0, 1, 1); #1;
    checks++; if (phys_rd !== 6'd32 || old_phys_rd !== 6'd1) begin errors++; $display("FAIL x0_tag0_not_freed: got phys %0d old %0d expected 32 1", phys_rd, old_phys_rd); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(); rename_in(0, 0, 3, 1); #1;
    step(); rename_in(0, 0, 4, 1); #1;
    step(); rename_in(0, 0, 3, 1); reset_n = 0; #1;
    checks++; if (free_count !== 7'd32 || in_ready !== 1'b0 || phys_rd !== 6'd0) begin errors++; $display("FAIL async_reset: got count %0d ready %0b phys %0d expected 32 0 0", free_count, in_ready, phys_rd); end
    step(); reset_n = 1; rename_in(0, 0, 3, 1); #1;
    checks++; if (phys_rd !== 6'd32 || old_phys_rd !== 6'd3) begin errors++; $display("FAIL after_async_reset: got phys %0d old %0d expected 32 3", phys_rd, old_phys_rd); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_chain();
    test_exhaust();
    test_bypass();
    test_flush();
    test_x0();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
